// File: rtl/pwm_multichannel_if.sv
// Control bus and PWM outputs of pwm_multichannel.
// Defining PWM_INVERT_EN adds the per-channel polarity vector.
interface pwm_multichannel_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic                      enable;
   logic [WIDTH-1:0]          period;
   logic [CHANNELS*WIDTH-1:0] duty;
   logic                      center_mode;
   logic                      duty_load;
`ifdef PWM_INVERT_EN
   logic [CHANNELS-1:0]       polarity;
`endif
   logic [CHANNELS-1:0]       pwm_out;
   logic                      period_end;
   logic                      update_pending;

`ifdef PWM_INVERT_EN
   modport master (output enable, period, duty, center_mode, duty_load, polarity,
                   input  pwm_out, period_end, update_pending);
   modport slave  (input  enable, period, duty, center_mode, duty_load, polarity,
                   output pwm_out, period_end, update_pending);
`else
   modport master (output enable, period, duty, center_mode, duty_load,
                   input  pwm_out, period_end, update_pending);
   modport slave  (input  enable, period, duty, center_mode, duty_load,
                   output pwm_out, period_end, update_pending);
`endif
endinterface

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with a shared edge/center-aligned counter and double-buffered settings.
// Optional PWM_INVERT_EN: per-channel output polarity applied ahead of the output register.
module pwm_multichannel #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic               clk,
   input logic               reset,
   pwm_multichannel_if.slave bus
);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   logic [WIDTH-1:0]          cnt;
   dir_t                      dir;
   logic [WIDTH-1:0]          period_s;
   logic [WIDTH-1:0]          period_a;
   logic [CHANNELS*WIDTH-1:0] duty_s;
   logic [CHANNELS*WIDTH-1:0] duty_a;
   logic                      mode_s;
   logic                      mode_a;
   logic                      pending;
   logic [CHANNELS-1:0]       pwm_q;
   logic                      period_end_q;
   logic                      terminal;
   logic                      transfer;
   logic [CHANNELS-1:0]       cmp;
   logic [CHANNELS-1:0]       pol;

`ifdef PWM_INVERT_EN
   assign pol = bus.polarity;
`else
   assign pol = '0;
`endif

   // A zero period makes every cycle terminal; period 1 in center mode ends while still counting up.
   always_comb begin
      terminal = 1'b0;
      if (period_a == '0)
         terminal = 1'b1;
      else if (!mode_a)
         terminal = (cnt == period_a);
      else
         terminal = (cnt == WIDTH'(1)) && ((dir == DIR_DOWN) || (period_a == WIDTH'(1)));
   end

   assign transfer = !bus.enable || terminal;

   always_comb begin
      cmp = '0;
      for (int i = 0; i < CHANNELS; i++)
         cmp[i] = (cnt < duty_a[i*WIDTH +: WIDTH]);
   end

   // A strobe on a transfer cycle bypasses the shadow wait and goes straight to the active set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt          <= '0;
         dir          <= DIR_UP;
         period_s     <= '1;
         period_a     <= '1;
         duty_s       <= '0;
         duty_a       <= '0;
         mode_s       <= 1'b0;
         mode_a       <= 1'b0;
         pending      <= 1'b0;
         pwm_q        <= pol;
         period_end_q <= 1'b0;
      end else begin
         if (bus.duty_load) begin
            period_s <= bus.period;
            duty_s   <= bus.duty;
            mode_s   <= bus.center_mode;
         end

         if (transfer && bus.duty_load) begin
            period_a <= bus.period;
            duty_a   <= bus.duty;
            mode_a   <= bus.center_mode;
            pending  <= 1'b0;
         end else if (transfer && pending) begin
            period_a <= period_s;
            duty_a   <= duty_s;
            mode_a   <= mode_s;
            pending  <= 1'b0;
         end else if (bus.duty_load) begin
            pending  <= 1'b1;
         end

         if (!bus.enable) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            pwm_q        <= pol;
            period_end_q <= 1'b0;
         end else begin
            pwm_q        <= cmp ^ pol;
            period_end_q <= terminal;
            if (terminal) begin
               cnt <= '0;
               dir <= DIR_UP;
            end else if (!mode_a) begin
               cnt <= cnt + WIDTH'(1);
            end else if (dir == DIR_UP) begin
               if (cnt == period_a) begin
                  dir <= DIR_DOWN;
                  cnt <= cnt - WIDTH'(1);
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end else begin
               cnt <= cnt - WIDTH'(1);
            end
         end
      end
   end

   assign bus.pwm_out        = pwm_q;
   assign bus.period_end     = period_end_q;
   assign bus.update_pending = pending;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel (WIDTH=8, CHANNELS=2) using a phase-based period model.
// Exercises the polarity scenario when PWM_INVERT_EN is defined.
`timescale 1ns/1ps
module tb_pwm_multichannel;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 2;

   logic clk = 1'b0;
   logic reset;
   bit   check_en = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   pwm_multichannel_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

   pwm_multichannel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // The model tracks position within the current period instead of a counter and direction.
   typedef struct {
      int                                k;
      int                                pa;
      logic [CHANNELS-1:0][WIDTH-1:0]    da;
      bit                                ma;
      int                                ps;
      logic [CHANNELS-1:0][WIDTH-1:0]    ds;
      bit                                ms;
      bit                                pend;
      bit   [CHANNELS-1:0]               out;
      bit                                pe;
   } model_t;

   model_t m;

   function automatic model_t model_step(model_t s);
      model_t            n = s;
      bit [CHANNELS-1:0] pol = '0;
      int                len;
      int                c;
      bit                last;
      bit                xfer;
`ifdef PWM_INVERT_EN
      pol = bus.polarity;
`endif
      if (!reset) begin
         n.k = 0; n.pa = 255; n.ps = 255; n.da = '0; n.ds = '0;
         n.ma = 1'b0; n.ms = 1'b0; n.pend = 1'b0; n.out = pol; n.pe = 1'b0;
         return n;
      end
      len  = (s.pa == 0) ? 1 : (s.ma ? 2 * s.pa : s.pa + 1);
      last = (s.k == len - 1);
      xfer = !bus.enable || last;
      if (bus.enable) begin
         c = (s.k <= s.pa) ? s.k : 2 * s.pa - s.k;
         for (int i = 0; i < CHANNELS; i++)
            n.out[i] = (c < int'(s.da[i])) ^ pol[i];
         n.pe = last;
         n.k  = last ? 0 : s.k + 1;
      end else begin
         n.k = 0; n.out = pol; n.pe = 1'b0;
      end
      if (bus.duty_load) begin
         n.ps = int'(bus.period); n.ds = bus.duty; n.ms = bus.center_mode;
      end
      if (xfer && bus.duty_load) begin
         n.pa = int'(bus.period); n.da = bus.duty; n.ma = bus.center_mode; n.pend = 1'b0;
      end else if (xfer && s.pend) begin
         n.pa = s.ps; n.da = s.ds; n.ma = s.ms; n.pend = 1'b0;
      end else if (bus.duty_load) begin
         n.pend = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_step(m);

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check_output("model pwm_out", 32'(bus.pwm_out), 32'(m.out));
         check_output("model period_end", 32'(bus.period_end), 32'(m.pe));
         check_output("model update_pending", 32'(bus.update_pending), 32'(m.pend));
      end
   end

   // Loads a full setting while idle, then starts the counter from zero.
   task automatic apply_stimulus(input int p, input int d0, input int d1, input bit cm);
      @(negedge clk);
      bus.enable      = 1'b0;
      bus.period      = 8'(p);
      bus.duty        = {8'(d1), 8'(d0)};
      bus.center_mode = cm;
      bus.duty_load   = 1'b1;
      @(negedge clk);
      bus.duty_load   = 1'b0;
      @(negedge clk);
      bus.enable      = 1'b1;
   endtask

   task automatic count_window(input int n, output int c0, output int c1, output int pe);
      c0 = 0; c1 = 0; pe = 0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         c0 += int'(bus.pwm_out[0]);
         c1 += int'(bus.pwm_out[1]);
         pe += int'(bus.period_end);
      end
   endtask

   task automatic sync_period_end();
      bit seen = 1'b0;
      for (int j = 0; j < 600 && !seen; j++) begin
         @(negedge clk);
         if (bus.period_end === 1'b1) seen = 1'b1;
      end
      if (!seen) check_output("period_end timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0, c1, pe;
      int h0, h1;
      reset           = 1'b0;
      bus.enable      = 1'b0;
      bus.period      = '0;
      bus.duty        = '0;
      bus.center_mode = 1'b0;
      bus.duty_load   = 1'b0;
`ifdef PWM_INVERT_EN
      bus.polarity    = '0;
`endif
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      check_output("reset pwm_out", 32'(bus.pwm_out), 32'(0));
      check_output("reset period_end", 32'(bus.period_end), 32'(0));
      check_output("reset update_pending", 32'(bus.update_pending), 32'(0));
      reset = 1'b1;

      $display("[TB] edge mode P=9 D={3,0}");
      apply_stimulus(9, 3, 0, 1'b0);
      repeat (3) @(negedge clk);
      count_window(30, c0, c1, pe);
      check_output("edge ch0 high count", 32'(c0), 32'(9));
      check_output("edge ch1 high count", 32'(c1), 32'(0));
      check_output("edge period_end count", 32'(pe), 32'(3));

      $display("[TB] duty above period");
      apply_stimulus(9, 10, 255, 1'b0);
      repeat (3) @(negedge clk);
      count_window(20, c0, c1, pe);
      check_output("over ch0 high count", 32'(c0), 32'(20));
      check_output("over ch1 high count", 32'(c1), 32'(20));

      $display("[TB] zero period");
      apply_stimulus(0, 1, 0, 1'b0);
      repeat (2) @(negedge clk);
      count_window(20, c0, c1, pe);
      check_output("p0 ch0 high count", 32'(c0), 32'(20));
      check_output("p0 ch1 high count", 32'(c1), 32'(0));
      check_output("p0 period_end count", 32'(pe), 32'(20));

      $display("[TB] mid-period update");
      apply_stimulus(9, 3, 0, 1'b0);
      sync_period_end();
      h0 = 0; h1 = 0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (j <= 10) h0 += int'(bus.pwm_out[0]);
         else         h1 += int'(bus.pwm_out[0]);
         if (j == 5) begin
            check_output("mid pending set", 32'(bus.update_pending), 32'(1));
            bus.duty_load = 1'b0;
         end
         if (j == 10) begin
            check_output("mid boundary period_end", 32'(bus.period_end), 32'(1));
            check_output("mid pending cleared", 32'(bus.update_pending), 32'(0));
         end
         if (j == 4) begin
            bus.duty      = {8'd0, 8'd7};
            bus.duty_load = 1'b1;
         end
      end
      check_output("mid old period highs", 32'(h0), 32'(3));
      check_output("mid new period highs", 32'(h1), 32'(7));

      $display("[TB] center mode P=4 D0=2, load on terminal");
      apply_stimulus(4, 2, 0, 1'b1);
      sync_period_end();
      h0 = 0; h1 = 0;
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         if (j <= 8)  h0 += int'(bus.pwm_out[0]);
         if (j >= 17) h1 += int'(bus.pwm_out[0]);
         if (j == 8) check_output("center period_end", 32'(bus.period_end), 32'(1));
         if (j == 16) begin
            check_output("center load period_end", 32'(bus.period_end), 32'(1));
            check_output("center load no pending", 32'(bus.update_pending), 32'(0));
            bus.duty_load = 1'b0;
         end
         if (j == 15) begin
            bus.duty      = {8'd0, 8'd4};
            bus.duty_load = 1'b1;
         end
      end
      check_output("center D2 highs", 32'(h0), 32'(3));
      check_output("center D4 highs", 32'(h1), 32'(7));

      $display("[TB] reset mid-period");
      apply_stimulus(9, 3, 0, 1'b0);
      sync_period_end();
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 1) begin
            bus.duty      = {8'd0, 8'd7};
            bus.duty_load = 1'b1;
         end
         if (j == 2) bus.duty_load = 1'b0;
         if (j == 5) begin
            check_output("pre-reset pending", 32'(bus.update_pending), 32'(1));
            reset = 1'b0;
         end
         if (j == 6) begin
            check_output("mid reset pwm_out", 32'(bus.pwm_out), 32'(0));
            check_output("mid reset period_end", 32'(bus.period_end), 32'(0));
            check_output("mid reset pending", 32'(bus.update_pending), 32'(0));
            reset = 1'b1;
         end
      end
      count_window(20, c0, c1, pe);
      check_output("post reset ch0 highs", 32'(c0), 32'(0));
      check_output("post reset period_end", 32'(pe), 32'(0));

`ifdef PWM_INVERT_EN
      $display("[TB] polarity 2'b01");
      @(negedge clk);
      bus.enable   = 1'b0;
      bus.polarity = 2'b01;
      repeat (2) @(negedge clk);
      check_output("idle polarity pwm_out", 32'(bus.pwm_out), 32'(1));
      apply_stimulus(9, 3, 0, 1'b0);
      repeat (3) @(negedge clk);
      count_window(30, c0, c1, pe);
      check_output("invert ch0 high count", 32'(c0), 32'(21));
      check_output("invert ch1 high count", 32'(c1), 32'(0));
`endif

      @(negedge clk);
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator, the next generation of the team's single-channel `PWM_generator`. CHANNELS outputs share one WIDTH-bit period counter and a programmable period register. Each channel has its own duty value. Duty, period and mode updates are double-buffered and take effect only at a period boundary, so the output never produces a glitched cycle. Edge-aligned and center-aligned counting are both supported. The block sits between the control registers and the motor, LED or driver pins.

## Interface
- `WIDTH`, 8: bit width of the counter, period and each duty value.
- `CHANNELS`, 4: number of PWM outputs.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: run when high; when low, hold idle.
- `period` in WIDTH: terminal count P.
- `duty` in CHANNELS*WIDTH: per-channel duty D[i]; channel i occupies bits [i*WIDTH +: WIDTH].
- `center_mode` in 1: 0 selects edge-aligned, 1 selects center-aligned.
- `duty_load` in 1: one-cycle strobe; captures `period`, `duty` and `center_mode` into the shadow registers.
- `pwm_out` out CHANNELS: PWM outputs, registered.
- `period_end` out 1: one-cycle pulse after each completed period.
- `update_pending` out 1: high while shadow values wait for a boundary.

## Operation
- **Registers.** Shadow set (P_s, D_s[], M_s) and active set (P_a, D_a[], M_a).
  - `duty_load` writes the shadow set and sets `update_pending`.
- **Edge mode (M_a=0).**
  - cnt counts 0..P_a, then wraps to 0.
  - Period = P_a+1 cycles.
  - Terminal cycle: cnt==P_a.
- **Center mode (M_a=1).**
  - cnt counts up 0..P_a, then down P_a-1..1, then repeats.
  - Period = 2*P_a cycles.
  - Terminal cycle: cnt==1 while counting down.
  - P_a==1 gives the sequence 0,1: terminal is cnt==1.
  - P_a==0: cnt holds at 0; every cycle is terminal (1-cycle period). Same in edge mode.
- **Compare.** Each cycle, next pwm_out[i] = (cnt < D_a[i]).
  - Edge mode: high for min(D, P+1) of P+1 cycles.
  - Center mode, 1≤D≤P: high for 2D-1 of 2P cycles, centred on cnt==0.
  - D==0 gives 0% duty. D>P gives 100% duty in both modes.
- **Boundary transfer.** In the terminal cycle, if `update_pending`:
  - Active set <= shadow set; `update_pending` <= 0.
  - cnt <= 0 and direction <= up.
- **Simultaneous events.**
  - `duty_load` in the terminal cycle: the newly strobed bus values are transferred directly to the active set and become active for the next period. `update_pending` stays 0.
  - `duty_load` while already pending: shadow values are overwritten; the last strobe wins.
- **enable low.**
  - cnt <= 0, direction <= up, pwm_out <= 0, `period_end` <= 0.
  - Pending shadow values transfer immediately.
  - When `enable` rises, the first period starts at cnt=0.
- **Arithmetic.** Counter comparisons are unsigned. No wrap beyond P_a, including P_a = 2^WIDTH-1.

## Timing
- **Reset (reset==0 at a clk edge), all of these take effect on the next edge:**
  - cnt=0, direction up.
  - P_s=P_a=all ones; D_s=D_a=0; M_s=M_a=0.
  - pwm_out=0, period_end=0, update_pending=0.
- **Reset mid-period:** the same values apply on the next edge; pending updates are discarded.
- **Output latency:** pwm_out lags the cnt/D_a values it is compared against by one clock.
- **`period_end`:** high for exactly one cycle, the cycle after each terminal cycle, while enabled.
- **Duty update:** a `duty_load` at cycle t in a non-terminal cycle first affects pwm_out 1 cycle after the next terminal cycle.

## Configuration
- **`PWM_INVERT_EN`**
  - Defined: adds input `polarity` [CHANNELS-1:0]. Each pwm_out[i] = compare result XOR polarity[i]. The inversion is applied before the output register and is not shadowed. While reset or `enable` low, pwm_out[i] = polarity[i].
  - Undefined: no `polarity` port; outputs are active-high as described above.

## Test plan
All scenarios use WIDTH=8, CHANNELS=2.
- **Edge mode, two duties.** Load P=9, D={3,0}, enable=1. Expect pwm_out[0] high 3 of every 10 cycles and pwm_out[1] constant 0. `period_end` pulses every 10 cycles.
- **Edge cases.** P=9, D={10,255}: both outputs constant high. P=0, D={1,0}: ch0 constant high, `period_end` high every cycle.
- **Mid-period update.** Running with P=9, D0=3, strobe D0=7 at cnt=4. Expect `update_pending`=1 and the current period still 3 high. The next period is 7 high; pending clears at the boundary.
- **Center mode and load on terminal.** P=4, D0=2, center_mode=1: 8-cycle period, ch0 high 3 cycles (cnt 1,0,1 region). A strobe coinciding with the terminal cycle applies to the following period with `update_pending` staying 0.
- **Reset mid-period.** Pull reset low at cnt=5. Next edge: all outputs 0, P_a=255, D_a=0, and the pending flag is cleared.
- **`PWM_INVERT_EN` defined.** polarity=2'b01, D={3,0}, P=9. Expect ch0 low 3 of 10 cycles and ch1 constant 0. With enable=0: pwm_out=2'b01.
